// File: rtl/config_stream_loader_if.sv
// config_stream_loader_if
//   The host word stream and the configuration-controller write port of the
//   loader, bundled together.
//   master : loader side (takes host_data/host_valid/cfg_done,
//            drives host_ready/cfg_wren/cfg_addr/cfg_data)
//   slave  : environment side (host plus controller)
interface config_stream_loader_if #(
    parameter int WIDTH = 40
);
    logic [WIDTH-1:0] host_data;
    logic             host_valid;
    logic             host_ready;
    logic             cfg_wren;
    logic [31:0]      cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic             cfg_done;

    modport master (
        input  host_data, host_valid, cfg_done,
        output host_ready, cfg_wren, cfg_addr, cfg_data
    );

    modport slave (
        output host_data, host_valid, cfg_done,
        input  host_ready, cfg_wren, cfg_addr, cfg_data
    );
endinterface

// File: rtl/config_stream_loader.sv
// config_stream_loader
//   Sits upstream of the serial configuration controller. Takes the bitstream
//   from the host as WIDTH-bit words, buffers them in a small FIFO, and
//   replays them as a write stream. Gaps in the stream are allowed. The first
//   word of a load carries cfg_addr = 1. After TOTAL words the loader adds one
//   flush write of zero, then waits for cfg_done.
//   Ports: clk, reset (async, active high), start (pulse that begins a load),
//          bus (host_* handshake and cfg_* write port, master modport),
//          busy / loaded / error status, word_count (words emitted this load).
//   Optional: define CFG_LOADER_TIMEOUT_EN to add a stall watchdog that moves
//   the loader to ERROR after TIMEOUT_CYCLES cycles without progress.
module config_stream_loader #(
    parameter int WIDTH          = 40,
    parameter int STAGES         = 16,
    parameter int LUTSIZE        = 6,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    config_stream_loader_if.master  bus,
    output logic                    busy,
    output logic                    loaded,
    output logic                    error,
    output logic [15:0]             word_count
);
    localparam int          TOTAL   = STAGES << LUTSIZE;
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] TOTAL_W = 16'(TOTAL);

    if (TOTAL < 1 || TOTAL > 65535) begin : g_total_chk
        $error("config_stream_loader: TOTAL must fit 16 bits");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("config_stream_loader: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("config_stream_loader: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, STREAM, FLUSH, WAIT_DONE, LOADED, ERROR} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_cnt;
    logic [15:0]      accept_count;
    logic             fifo_full, fifo_empty, push, pop, load_start, fifo_clr, stall_timeout;
    logic             wren_nx;
    logic [31:0]      addr_nx;
    logic [WIDTH-1:0] data_nx;

    assign fifo_full      = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty     = (fifo_cnt == '0);
    assign bus.host_ready = (state == STREAM) && !fifo_full && (accept_count < TOTAL_W);
    assign push           = bus.host_valid && bus.host_ready;
    // Pop reads only the registered count, so a word pushed at one edge is
    // popped at the next edge. There is no bypass path.
    assign pop            = (state == STREAM) && !fifo_empty && (word_count < TOTAL_W);
    assign load_start     = start && (state == IDLE || state == LOADED || state == ERROR);
    assign fifo_clr       = load_start || (state_nx == ERROR && state != ERROR);

`ifdef CFG_LOADER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_cnt;
    logic          stalling;

    assign stalling      = (state == STREAM && fifo_empty && !push) || (state == WAIT_DONE);
    assign stall_timeout = stalling && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          stall_cnt <= '0;
        else if (push || state_nx != state) stall_cnt <= '0;
        else if (stalling)                  stall_cnt <= stall_cnt + SW'(1);
    end
`else
    assign stall_timeout = 1'b0;
`endif

    // Next state, together with the values the registered cfg_* outputs take
    // at the next edge.
    always_comb begin
        state_nx = state;
        wren_nx  = 1'b0;
        addr_nx  = 32'd0;
        data_nx  = '0;
        case (state)
            IDLE, LOADED, ERROR: if (start) state_nx = STREAM;
            STREAM: begin
                if (pop) begin
                    wren_nx = 1'b1;
                    data_nx = mem[rd_ptr];
                    addr_nx = (word_count == 16'd0) ? 32'd1 : 32'd0;
                    if (word_count == TOTAL_W - 16'd1) state_nx = FLUSH;
                end else if (stall_timeout) begin
                    state_nx = ERROR;
                end
            end
            FLUSH: begin
                // The flush write pushes the last stage token out of the controller.
                wren_nx  = 1'b1;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.cfg_done)       state_nx = LOADED;
                else if (stall_timeout) state_nx = ERROR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO storage has no reset. Only words the pointers have covered are read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.host_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            accept_count <= '0;
            word_count   <= '0;
            bus.cfg_wren <= 1'b0;
            bus.cfg_addr <= 32'd0;
            bus.cfg_data <= '0;
            busy         <= 1'b0;
            loaded       <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nx;
            bus.cfg_wren <= wren_nx;
            bus.cfg_addr <= addr_nx;
            bus.cfg_data <= data_nx;
            busy         <= (state_nx == STREAM) || (state_nx == FLUSH) || (state_nx == WAIT_DONE);
            loaded       <= (state_nx == LOADED);
            error        <= (state_nx == ERROR);

            if (fifo_clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            end

            if (load_start) begin
                accept_count <= '0;
                word_count   <= '0;
            end else begin
                if (push) accept_count <= accept_count + 16'd1;
                if (pop)  word_count   <= word_count + 16'd1;
            end
        end
    end
endmodule
